accumulate_engine: RTL and testbench
====================================

// Module: accumulate_engine
// PURPOSE
//  In-place prefix-scan engine over an internal array of DEPTH signed words; generalises the
//  fixed 1000 x 64-bit accumulate kernel to parametrised width/depth, selectable scan mode,
//  start offset with wrap-around, run length and overflow reporting.
//  Host loads/reads the array through port A while idle; pulse r_enable to scan; w_enable
//  pulses on completion.
// PARAMETERS
//  W      64    data word width (signed, two's complement)
//  DEPTH  1000  array entries; need not be a power of two
//  AW     $clog2(DEPTH)  address width (derived, do not override)
// PORTS
//  clk                  in   1      clock; all logic on posedge
//  rst                  in   1      synchronous, active-high reset
//  r_enable             in   1      start pulse; sampled only in IDLE with controlArr=0
//  init_i_t_a           in   AW     first index of scan (must be < DEPTH, else clamped to 0)
//  init_acc_t_a         in   W      initial accumulator value
//  len                  in   AW+1   elements to process; values > DEPTH treated as DEPTH
//  mode                 in   2      accum_pkg::mode_e: SUM_WRAP, SUM_SAT, MAX, MIN
//  controlArr           in   1      1 = host owns port A (honoured only when not busy)
//  controlArrWEnable_a  in   1      host write enable
//  controlArrAddr_a     in   AW     host address (>= DEPTH: write dropped, rdata 0)
//  controlArrWData_a    in   W      host write data
//  controlArrRData_a    out  W      host read data, 1-cycle latency after address
//  w_enable             out  1      one-cycle done pulse
//  busy                 out  1      high from the cycle after accepted start until w_enable
//  result               out  W      final accumulator, held until next start
//  overflow             out  1      sticky per run: any signed overflow seen (SUM modes)
// BEHAVIOUR
//  Reset: state IDLE; w_enable=0, busy=0, result=0, overflow=0; array contents NOT cleared.
//  FSM: IDLE -> RD -> UPD -> (RD | DONE) -> IDLE.
//   IDLE: if r_enable & !controlArr: latch idx=init_i, acc=init_acc, cnt=min(len,DEPTH);
//         clear overflow; cnt==0 -> DONE, else -> RD.
//   RD:   drive read of arr[idx].
//   UPD:  d=rdata; acc'=f(acc,d); write arr[idx]=acc'; acc<=acc'; idx<=(idx==DEPTH-1)?0:idx+1;
//         cnt-=1; cnt reaches 0 -> DONE else -> RD.
//   DONE: result<=acc; w_enable=1 for this cycle only; -> IDLE.
//  Timing: start sampled in cycle 0 -> w_enable in cycle 2*cnt+1 (cnt=0 -> cycle 1).
//  f(): SUM_WRAP acc+d mod 2^W; SUM_SAT clamp to [-2^(W-1), 2^(W-1)-1];
//       MAX signed max(acc,d); MIN signed min(acc,d). Overflow = sign(acc)==sign(d) and
//       sign(sum)!=sign(acc); set in both SUM modes, never in MAX/MIN.
//  Element k written back is the inclusive scan of init_acc and elements 0..k.
//  Arbitration: while busy the engine owns the RAM; host writes dropped, host rdata 0.
//  r_enable while busy or with controlArr=1 is ignored (no queueing).
//  Start and host write in the same IDLE cycle: start is ignored because controlArr=1.
//  Wrap: index DEPTH-1 is followed by 0; a full-length run from offset s covers every
//  entry once.
//  Reset mid-run: abort to IDLE next edge, no w_enable; entries already written stay updated.
//  mode sampled at start only; changes mid-run have no effect.
// STRUCTURE
//  accum_pkg: mode_e enum (2 bits), saturation MAX/MIN constants as functions of W,
//   state_e enum.
//  Sub-module accum_ram: single-port sync RAM (W x DEPTH, 1-cycle read, write-first not
//   required). The engine holds the FSM, the address/data mux between host and engine,
//   and the combinational f().
// TESTING
//  1 DEPTH=1000, load 1000 random 32-bit-range values, init 0, len 1000, SUM_WRAP ->
//    arr[k]=prefix sums, w_enable at cycle 2001, result=total.
//  2 W=8, SUM_SAT, data {100,100,-128,-128,-128}, init 0 -> arr {100,127,-1,-128,-128},
//    overflow=1.
//  3 W=8, SUM_WRAP, {127,1}, init 0 -> arr {127,-128}, overflow=1, result=-128.
//  4 DEPTH=8, init_i=6, len=4, MAX, data[6,7,0,1]={3,-5,9,2}, init_acc=-100 ->
//    {3,3,9,9}, entries 2..5 unchanged.
//  5 len=0 -> w_enable one cycle after start, result=init_acc, array untouched; len=DEPTH+5
//    behaves as DEPTH.
//  6 rst asserted mid-run at element 3 -> no w_enable, busy=0 next cycle, elements 0..2
//    updated, rest unchanged; a new start then succeeds.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types for the accumulate engine: scan modes, FSM states and the
// signed saturation limits for an arbitrary word width.
package accum_pkg;

    typedef enum logic [1:0] {
        SUM_WRAP = 2'd0,
        SUM_SAT  = 2'd1,
        MAX      = 2'd2,
        MIN      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_UPD  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int SAT_CW = 128;

    // Limits are built wide and truncated by the caller to its own word width.
    function automatic logic [SAT_CW-1:0] sat_max(input int w);
        return (SAT_CW'(1) << (w - 1)) - SAT_CW'(1);
    endfunction

    function automatic logic [SAT_CW-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/accum_ram.sv
// Single-port synchronous RAM, registered read data (one-cycle latency).
module accum_ram #(
    parameter int W     = 64,
    parameter int DEPTH = 1000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/accumulate_engine.sv
// In-place prefix-scan engine: the host owns the RAM while idle; a start pulse
// runs one RD/UPD pair per element, writing each running accumulator back.
module accumulate_engine
    import accum_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 1000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r_enable,
    input  logic [AW-1:0] init_i_t_a,
    input  logic [W-1:0]  init_acc_t_a,
    input  logic [AW:0]   len,
    input  logic [1:0]    mode,
    input  logic          controlArr,
    input  logic          controlArrWEnable_a,
    input  logic [AW-1:0] controlArrAddr_a,
    input  logic [W-1:0]  controlArrWData_a,
    output logic [W-1:0]  controlArrRData_a,
    output logic          w_enable,
    output logic          busy,
    output logic [W-1:0]  result,
    output logic          overflow,
    output state_e        dbg_state_o
);

    localparam logic [W-1:0] SAT_MAX_W = W'(sat_max(W));
    localparam logic [W-1:0] SAT_MIN_W = W'(sat_min(W));
    localparam logic [AW:0]  DEPTH_CNT = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [AW:0]   cnt_q, cnt_d;
    mode_e         mode_q, mode_d;
    logic [W-1:0]  result_q, result_d;
    logic          ovf_q, ovf_d;
    logic          host_rd_ok_q, host_rd_ok_d;

    logic          eng_busy, eng_we, host_addr_ok;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata, ram_rdata;
    logic [W-1:0]  sum, f_val;
    logic          sum_ovf;

    // Start handshake: r_enable is a single-cycle request taken only in IDLE with
    // controlArr low; w_enable is the single-cycle completion pulse, busy spans both.
    assign eng_busy     = (state_q != S_IDLE);
    assign host_addr_ok = (32'(controlArrAddr_a) < DEPTH);

    assign sum     = acc_q + ram_rdata;
    assign sum_ovf = (acc_q[W-1] == ram_rdata[W-1]) && (sum[W-1] != acc_q[W-1]);

    always_comb begin
        f_val = sum;
        case (mode_q)
            SUM_WRAP: f_val = sum;
            SUM_SAT:  if (sum_ovf) f_val = acc_q[W-1] ? SAT_MIN_W : SAT_MAX_W;
            MAX:      f_val = ($signed(ram_rdata) > $signed(acc_q)) ? ram_rdata : acc_q;
            MIN:      f_val = ($signed(ram_rdata) < $signed(acc_q)) ? ram_rdata : acc_q;
            default:  f_val = sum;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        eng_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (r_enable && !controlArr) begin
                    idx_d   = (32'(init_i_t_a) < DEPTH) ? init_i_t_a : '0;
                    acc_d   = init_acc_t_a;
                    cnt_d   = (32'(len) > DEPTH) ? DEPTH_CNT : len;
                    mode_d  = mode_e'(mode);
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: state_d = S_UPD;
            S_UPD: begin
                eng_we = 1'b1;
                acc_d  = f_val;
                if (mode_q == SUM_WRAP || mode_q == SUM_SAT) begin
                    ovf_d = ovf_q | sum_ovf;
                end
                idx_d   = (32'(idx_q) == DEPTH - 1) ? '0 : idx_q + AW'(1);
                cnt_d   = cnt_q - (AW+1)'(1);
                state_d = (cnt_q == (AW+1)'(1)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                result_d = acc_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A reset during UPD must not leave a half-finished write behind.
    assign ram_we    = eng_busy ? (eng_we && !rst)
                                : (controlArr && controlArrWEnable_a && host_addr_ok);
    assign ram_addr  = eng_busy ? idx_q : (host_addr_ok ? controlArrAddr_a : '0);
    assign ram_wdata = eng_busy ? f_val : controlArrWData_a;
    assign host_rd_ok_d = !eng_busy && host_addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= SUM_WRAP;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            host_rd_ok_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            host_rd_ok_q <= host_rd_ok_d;
        end
    end

    accum_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign controlArrRData_a = (host_rd_ok_q && !eng_busy) ? ram_rdata : '0;
    assign w_enable          = (state_q == S_DONE);
    assign busy              = eng_busy;
    assign result            = (state_q == S_DONE) ? acc_q : result_q;
    assign overflow          = ovf_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_accumulate_engine.sv
// Bench for accumulate_engine: a 64x1000 instance and an 8x8 instance share one
// set of host tasks; a behavioural scan model predicts memory, timing and results.
module tb_accumulate_engine;
    import accum_pkg::*;

    typedef logic signed [63:0] v64_t;
    localparam int B_W = 64, B_D = 1000, B_AW = 10;
    localparam int S_W = 8,  S_D = 8,    S_AW = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int     sel = 0;
    logic   t_ren = 1'b0, t_ctrl = 1'b0, t_we = 1'b0;
    int     t_addr = 0, t_init = 0, t_len = 0;
    v64_t   t_wdata = '0, t_acc = '0;
    logic [1:0] t_mode = 2'd0;

    logic b_ren, b_ctrl, b_we, b_wen, b_busy, b_ovf;
    logic [B_AW-1:0] b_addr, b_init;
    logic [B_AW:0]   b_len;
    logic [B_W-1:0]  b_wdata, b_acc, b_rdata, b_result;
    state_e          b_state;
    logic s_ren, s_ctrl, s_we, s_wen, s_busy, s_ovf;
    logic [S_AW-1:0] s_addr, s_init;
    logic [S_AW:0]   s_len;
    logic [S_W-1:0]  s_wdata, s_acc, s_rdata, s_result;
    state_e          s_state;

    assign b_ren   = (sel == 0) && t_ren;
    assign b_ctrl  = (sel == 0) && t_ctrl;
    assign b_we    = (sel == 0) && t_we;
    assign b_addr  = B_AW'(t_addr);
    assign b_init  = B_AW'(t_init);
    assign b_len   = (B_AW+1)'(t_len);
    assign b_wdata = t_wdata;
    assign b_acc   = t_acc;
    assign s_ren   = (sel == 1) && t_ren;
    assign s_ctrl  = (sel == 1) && t_ctrl;
    assign s_we    = (sel == 1) && t_we;
    assign s_addr  = S_AW'(t_addr);
    assign s_init  = S_AW'(t_init);
    assign s_len   = (S_AW+1)'(t_len);
    assign s_wdata = S_W'(t_wdata);
    assign s_acc   = S_W'(t_acc);

    accumulate_engine #(.W(B_W), .DEPTH(B_D)) u_big (
        .clk(clk), .rst(rst), .r_enable(b_ren), .init_i_t_a(b_init), .init_acc_t_a(b_acc),
        .len(b_len), .mode(t_mode), .controlArr(b_ctrl), .controlArrWEnable_a(b_we),
        .controlArrAddr_a(b_addr), .controlArrWData_a(b_wdata), .controlArrRData_a(b_rdata),
        .w_enable(b_wen), .busy(b_busy), .result(b_result), .overflow(b_ovf),
        .dbg_state_o(b_state)
    );

    accumulate_engine #(.W(S_W), .DEPTH(S_D)) u_small (
        .clk(clk), .rst(rst), .r_enable(s_ren), .init_i_t_a(s_init), .init_acc_t_a(s_acc),
        .len(s_len), .mode(t_mode), .controlArr(s_ctrl), .controlArrWEnable_a(s_we),
        .controlArrAddr_a(s_addr), .controlArrWData_a(s_wdata), .controlArrRData_a(s_rdata),
        .w_enable(s_wen), .busy(s_busy), .result(s_result), .overflow(s_ovf),
        .dbg_state_o(s_state)
    );

    // scoreboard / model state
    int   n_vec = 0, n_err = 0;
    v64_t exp_q[$];
    logic rd_tag = 1'b0, rd_due = 1'b0;
    logic chk_en = 1'b0;
    v64_t mem_m [2][B_D];
    v64_t old_res = '0, fin_res = '0;
    logic old_ovf = 1'b0, fin_ovf = 1'b0;
    int   run_start = 0, run_end = 0, run_done = -1;

    task automatic check(input string name, input v64_t act, input v64_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int depth_of(input int s);
        return (s == 1) ? S_D : B_D;
    endfunction

    function automatic int w_of(input int s);
        return (s == 1) ? S_W : B_W;
    endfunction

    function automatic v64_t wrapv(input logic signed [127:0] v, input int w);
        logic signed [127:0] m, r;
        m = 128'sd1 <<< w;
        r = v & (m - 128'sd1);
        if (r >= (m >>> 1)) r = r - m;
        return v64_t'(r);
    endfunction

    function automatic v64_t act_result();
        return (sel == 1) ? {{56{s_result[7]}}, s_result} : b_result;
    endfunction

    function automatic logic act_ovf();
        return (sel == 1) ? s_ovf : b_ovf;
    endfunction

    // Whole-run model: plain arithmetic on the scan rules, applied up to `limit` writes.
    task automatic model_run(input int init_i, input v64_t acc0, input int len_v,
                             input mode_e m, input int limit);
        int dep, w, idx, cnt;
        logic signed [127:0] acc, d, s, hi, lo;
        logic ovf;
        dep = depth_of(sel);
        w   = w_of(sel);
        idx = (init_i < dep) ? init_i : 0;
        cnt = (len_v > dep) ? dep : len_v;
        hi  = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo  = -(128'sd1 <<< (w - 1));
        acc = wrapv(acc0, w);
        ovf = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            d = mem_m[sel][idx];
            s = acc + d;
            case (m)
                SUM_WRAP: begin
                    if (s > hi || s < lo) ovf = 1'b1;
                    acc = wrapv(s, w);
                end
                SUM_SAT: begin
                    if (s > hi)      begin acc = hi; ovf = 1'b1; end
                    else if (s < lo) begin acc = lo; ovf = 1'b1; end
                    else acc = s;
                end
                MAX:     acc = (d > acc) ? d : acc;
                default: acc = (d < acc) ? d : acc;
            endcase
            if (k < limit) mem_m[sel][idx] = v64_t'(acc);
            idx = (idx + 1) % dep;
        end
        old_res   = fin_res;
        old_ovf   = fin_ovf;
        fin_res   = v64_t'(acc);
        fin_ovf   = ovf;
        run_start = cyc;
        run_end   = cyc + 2 * cnt + 1;
        run_done  = run_end;
    endtask

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_busy, a_busy, a_wen, a_idle;
            v64_t a_rd;
            a_busy = (sel == 1) ? s_busy : b_busy;
            a_wen  = (sel == 1) ? s_wen  : b_wen;
            a_idle = (sel == 1) ? (s_state == S_IDLE) : (b_state == S_IDLE);
            a_rd   = (sel == 1) ? {{56{s_rdata[7]}}, s_rdata} : b_rdata;
            e_busy = (cyc > run_start) && (cyc <= run_end);
            check("busy", v64_t'(a_busy), v64_t'(e_busy));
            check("w_enable", v64_t'(a_wen), v64_t'(cyc == run_done));
            check("dbg_idle", v64_t'(a_idle), v64_t'(!e_busy));
            if (cyc <= run_start) begin
                check("result_held", act_result(), old_res);
                check("overflow_held", v64_t'(act_ovf()), v64_t'(old_ovf));
            end else if (cyc == run_done || cyc > run_end) begin
                check("result", act_result(), fin_res);
                check("overflow", v64_t'(act_ovf()), v64_t'(fin_ovf));
            end
            if (rd_due) begin
                if (exp_q.size() == 0) check("rd_queue_empty", 64'sd1, 64'sd0);
                else check("rdata", a_rd, exp_q.pop_front());
            end
            rd_due = rd_tag;
        end
    end

    // driver tasks
    task automatic host_write(input int addr, input v64_t data, input logic apply);
        @(posedge clk); #1;
        t_ctrl = 1'b1; t_we = 1'b1; t_addr = addr; t_wdata = data; t_ren = 1'b0;
        if (apply && addr < depth_of(sel)) mem_m[sel][addr] = wrapv(data, w_of(sel));
        @(posedge clk); #1;
        t_we = 1'b0; t_ctrl = 1'b0;
    endtask

    task automatic host_read(input int addr, input v64_t exp);
        @(posedge clk); #1;
        t_ctrl = 1'b1; t_we = 1'b0; t_addr = addr; rd_tag = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        rd_tag = 1'b0; t_ctrl = 1'b0;
    endtask

    task automatic read_model(input int first, input int count);
        for (int a = first; a < first + count; a++) host_read(a, mem_m[sel][a]);
    endtask

    task automatic start_run(input int init_i, input v64_t acc0, input int len_v,
                             input mode_e m, input logic ctrl, input int limit);
        @(posedge clk); #1;
        t_ren = 1'b1; t_ctrl = ctrl; t_we = 1'b0;
        t_init = init_i; t_acc = acc0; t_len = len_v; t_mode = 2'(m);
        if (!ctrl) model_run(init_i, acc0, len_v, m, limit);
        @(posedge clk); #1;
        t_ren = 1'b0; t_ctrl = 1'b0;
    endtask

    task automatic poke_start();
        @(posedge clk); #1;
        t_ren = 1'b1; t_mode = 2'(MAX); t_len = 1;
        @(posedge clk); #1;
        t_ren = 1'b0;
    endtask

    task automatic wait_done(input int exp_off, input int budget);
        int   waited;
        logic seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            if ((sel == 1) ? s_wen : b_wen) seen = 1'b1;
        end
        check("done_seen", v64_t'(seen), 64'sd1);
        if (seen) check("done_latency", v64_t'(cyc - run_start), v64_t'(exp_off));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        v64_t total, v;
        int   r;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run_start = cyc; run_end = cyc; run_done = -1;
        chk_en = 1'b1;
        idle_cycles(2);

        // 1: full-length SUM_WRAP prefix scan over 1000 random 32-bit values
        total = '0;
        for (int a = 0; a < B_D; a++) begin
            r = $urandom;
            v = r;
            total = total + v;
            host_write(a, v, 1'b1);
        end
        start_run(0, 0, B_D, SUM_WRAP, 1'b0, B_D);
        wait_done(2001, 2100);
        check("t1_total", act_result(), total);
        read_model(0, B_D);

        // out-of-range host address: write dropped, read returns 0
        host_write(1005, 64'sd77, 1'b1);
        host_read(1005, 0);
        // init index beyond DEPTH clamps to 0
        start_run(1010, 7, 1, SUM_WRAP, 1'b0, 1);
        wait_done(3, 20);
        host_read(0, mem_m[0][0]);
        idle_cycles(2);

        // switch to the 8-bit / 8-entry instance
        @(posedge clk); #1;
        sel = 1;
        old_res = '0; fin_res = '0; old_ovf = 1'b0; fin_ovf = 1'b0;
        run_start = cyc; run_end = cyc; run_done = -1;
        idle_cycles(1);

        // 2: saturating sum
        host_write(0, 100, 1'b1); host_write(1, 100, 1'b1); host_write(2, -128, 1'b1);
        host_write(3, -128, 1'b1); host_write(4, -128, 1'b1);
        start_run(0, 0, 5, SUM_SAT, 1'b0, 5);
        wait_done(11, 30);
        check("t2_result", act_result(), -128);
        check("t2_overflow", v64_t'(act_ovf()), 1);
        host_read(0, 100); host_read(1, 127); host_read(2, -1);
        host_read(3, -128); host_read(4, -128);

        // 3: wrapping sum overflow
        host_write(0, 127, 1'b1); host_write(1, 1, 1'b1);
        start_run(0, 0, 2, SUM_WRAP, 1'b0, 2);
        wait_done(5, 30);
        check("t3_result", act_result(), -128);
        check("t3_overflow", v64_t'(act_ovf()), 1);
        host_read(0, 127); host_read(1, -128);

        // 4: MAX from offset 6 wrapping to 0
        host_write(6, 3, 1'b1); host_write(7, -5, 1'b1); host_write(0, 9, 1'b1);
        host_write(1, 2, 1'b1); host_write(2, 11, 1'b1); host_write(3, 22, 1'b1);
        host_write(4, 33, 1'b1); host_write(5, 44, 1'b1);
        start_run(6, -100, 4, MAX, 1'b0, 4);
        wait_done(9, 30);
        check("t4_overflow", v64_t'(act_ovf()), 0);
        host_read(6, 3); host_read(7, 3); host_read(0, 9); host_read(1, 9);
        host_read(2, 11); host_read(3, 22); host_read(4, 33); host_read(5, 44);

        // 5: len 0 and len beyond DEPTH
        start_run(0, 42, 0, SUM_WRAP, 1'b0, 0);
        wait_done(1, 10);
        check("t5_result", act_result(), 42);
        read_model(0, S_D);
        start_run(3, 0, S_D + 5, MIN, 1'b0, S_D);
        wait_done(17, 40);
        read_model(0, S_D);

        // ignored start (controlArr high) and host traffic during a run
        start_run(0, 0, 3, SUM_WRAP, 1'b1, 0);
        idle_cycles(4);
        start_run(0, 1, 4, SUM_SAT, 1'b0, 4);
        host_write(2, 99, 1'b0);
        poke_start();
        host_read(3, 0);
        wait_done(9, 30);
        read_model(0, S_D);

        // 6: reset in the RD cycle of element 3, then a fresh run
        for (int a = 0; a < S_D; a++) host_write(a, a * 3 - 10, 1'b1);
        start_run(0, 0, S_D, SUM_WRAP, 1'b0, 3);
        while (cyc < run_start + 7) begin @(posedge clk); #1; end
        rst = 1'b1;
        run_end = cyc; run_done = -1; fin_res = '0; fin_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        read_model(0, S_D);
        start_run(2, 5, 3, MAX, 1'b0, 3);
        wait_done(7, 30);
        read_model(0, S_D);
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
